// File: rtl/ifc_seq_pkg.sv
// Shared constants and payload types for the command sequencer.
package ifc_seq_pkg;

    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned DEF_DATA_W = 1;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    typedef struct packed {
        logic                  op;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } cmd_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a count register; full/empty decode from the count.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_data   write request and data (ignored when full)
//   i_pop            read request (ignored when empty)
//   o_head_c         entry at the read pointer
//   o_full_c         count == DEPTH
//   o_empty_c        count == 0
module sync_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_c,
    output logic             o_full_c,
    output logic             o_empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full_c  = (r_count == FULL_CNT);
    assign o_empty_c = (r_count == '0);
    assign w_push    = i_push & ~o_full_c;
    assign w_pop     = i_pop & ~o_empty_c;
    assign o_head_c  = r_mem[r_rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/ifc_cmd_sequencer.sv
// In-order command sequencer driving a write/read method interface.
// Commands are queued, issued one per cycle from the queue head when the
// target method is ready, and read results are queued as responses.
// Ports:
//   CLK, RST_N                       clock, asynchronous active-low reset
//   cmd_valid/ready/op/addr/data     command stream in (op 0=write, 1=read)
//   rsp_valid/ready/addr/data        read response stream out
//   write_address/data/en, write_rdy write method
//   read_address/en, read_data/rdy   read method
//   busy                             either queue holds an entry
//   stall_cnt                        consecutive cycles the head was blocked (saturating)
//   err_timeout                      sticky: head blocked TIMEOUT cycles
module ifc_cmd_sequencer
    import ifc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              write_en,
    input  logic              write_rdy,
    output logic [ADDR_W-1:0] read_address,
    output logic              read_en,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_rdy,
    output logic              busy,
    output logic [15:0]       stall_cnt,
    output logic              err_timeout
);

    localparam int unsigned CMD_W   = 1 + ADDR_W + DATA_W;
    localparam int unsigned RSP_W   = ADDR_W + DATA_W;
    localparam int unsigned STALL_W = 16;
    localparam logic [STALL_W-1:0] STALL_MAX   = '1;
    localparam logic [STALL_W-1:0] TIMEOUT_CNT =
        (TIMEOUT > 32'd65535) ? STALL_MAX : STALL_W'(TIMEOUT);

    logic [CMD_W-1:0]   w_cmd_wdata;
    logic [CMD_W-1:0]   w_cmd_head;
    logic               w_cmd_push;
    logic               w_cmd_full;
    logic               w_cmd_empty;
    logic [RSP_W-1:0]   w_rsp_wdata;
    logic [RSP_W-1:0]   w_rsp_head;
    logic               w_rsp_pop;
    logic               w_rsp_full;
    logic               w_rsp_empty;
    logic               w_head_v;
    logic               w_head_op;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [DATA_W-1:0]  w_head_data;
    logic               w_wr_issue;
    logic               w_rd_issue;
    logic               w_issue;
    logic [STALL_W-1:0] w_stall_nxt;
    logic [STALL_W-1:0] r_stall_cnt;
    logic               r_err;

    // Command queue
    assign w_cmd_push  = cmd_valid & ~w_cmd_full;
    assign w_cmd_wdata = {cmd_op, cmd_addr, cmd_data};

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_push    (w_cmd_push),
        .i_data    (w_cmd_wdata),
        .i_pop     (w_issue),
        .o_head_c  (w_cmd_head),
        .o_full_c  (w_cmd_full),
        .o_empty_c (w_cmd_empty)
    );

    // Issue decision for the queue head
    assign w_head_v = ~w_cmd_empty;
    assign {w_head_op, w_head_addr, w_head_data} = w_cmd_head;

    assign w_wr_issue = w_head_v & (w_head_op == OP_WRITE) & write_rdy;
    // rsp_full comes from the registered count, so a same-cycle pop cannot make room.
    assign w_rd_issue = w_head_v & (w_head_op == OP_READ) & read_rdy & ~w_rsp_full;
    assign w_issue    = w_wr_issue | w_rd_issue;

    // Method-side outputs follow the head and read as zero when the queue is empty.
    assign write_en      = w_wr_issue;
    assign read_en       = w_rd_issue;
    assign write_address = w_head_v ? w_head_addr : '0;
    assign write_data    = w_head_v ? w_head_data : '0;
    assign read_address  = w_head_v ? w_head_addr : '0;

    // Response queue: read data captured in the read_en cycle with the head address
    assign w_rsp_wdata = {w_head_addr, read_data};
    assign w_rsp_pop   = rsp_ready & ~w_rsp_empty;

    sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_push    (w_rd_issue),
        .i_data    (w_rsp_wdata),
        .i_pop     (w_rsp_pop),
        .o_head_c  (w_rsp_head),
        .o_full_c  (w_rsp_full),
        .o_empty_c (w_rsp_empty)
    );

    assign cmd_ready = ~w_cmd_full;
    assign rsp_valid = ~w_rsp_empty;
    assign {rsp_addr, rsp_data} = rsp_valid ? w_rsp_head : '0;
    assign busy      = ~w_cmd_empty | ~w_rsp_empty;

    // Stall counter: any issue clears, a blocked head counts up and saturates, idle holds.
    always_comb begin
        w_stall_nxt = r_stall_cnt;
        if (w_issue) begin
            w_stall_nxt = '0;
        end else if (w_head_v && (r_stall_cnt != STALL_MAX)) begin
            w_stall_nxt = r_stall_cnt + STALL_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stall_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_stall_cnt <= w_stall_nxt;
            if (w_stall_nxt >= TIMEOUT_CNT) begin
                r_err <= 1'b1;
            end
        end
    end

    assign stall_cnt   = r_stall_cnt;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_ifc_cmd_sequencer.sv
// Bench for ifc_cmd_sequencer: directed scenarios plus random traffic,
// checked by a scoreboard fed from accepted commands and an 8x1 memory model.
module tb_ifc_cmd_sequencer;
    import ifc_seq_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [2:0]  cmd_addr;
    logic        cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_addr;
    logic        rsp_data;
    logic [2:0]  write_address;
    logic        write_data;
    logic        write_en;
    logic        write_rdy;
    logic [2:0]  read_address;
    logic        read_en;
    logic        read_data;
    logic        read_rdy;
    logic        busy;
    logic [15:0] stall_cnt;
    logic        err_timeout;

    // External memory the sequencer drives, and the bench's in-order image of it
    logic [7:0]  ext_mem = 8'hA8;
    logic [7:0]  shadow  = 8'hA8;

    cmd_t        exp_wr_q[$];
    logic [2:0]  exp_rd_q[$];
    rsp_t        exp_rsp_q[$];

    int          checks = 0;
    int          errors = 0;
    int          occ    = 0;
    int          rocc   = 0;
    cmd_t        rec_c;
    rsp_t        rec_r;
    cmd_t        mon_w;
    rsp_t        mon_r;
    logic [2:0]  mon_a;

    ifc_cmd_sequencer #(
        .CMD_DEPTH (DEPTH),
        .RSP_DEPTH (DEPTH),
        .TIMEOUT   (TMO)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_addr      (rsp_addr),
        .rsp_data      (rsp_data),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy),
        .busy          (busy),
        .stall_cnt     (stall_cnt),
        .err_timeout   (err_timeout)
    );

    always #5 CLK = ~CLK;

    assign read_data = ext_mem[read_address];

    always @(posedge CLK) begin
        if (RST_N && write_en) ext_mem[write_address] <= write_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stimulus recorder: each accepted command pushes its expected effects.
    always @(negedge CLK) begin
        if (!RST_N) begin
            exp_wr_q.delete();
            exp_rd_q.delete();
            exp_rsp_q.delete();
            shadow = ext_mem;
        end else if (cmd_valid && cmd_ready) begin
            if (cmd_op == OP_WRITE) begin
                rec_c.op   = OP_WRITE;
                rec_c.addr = cmd_addr;
                rec_c.data = cmd_data;
                exp_wr_q.push_back(rec_c);
                shadow[cmd_addr] = cmd_data;
            end else begin
                exp_rd_q.push_back(cmd_addr);
                rec_r.addr = cmd_addr;
                rec_r.data = shadow[cmd_addr];
                exp_rsp_q.push_back(rec_r);
            end
        end
    end

    // Monitor: compares every method access and response against the queues.
    always @(negedge CLK) begin
        if (!RST_N) begin
            occ  = 0;
            rocc = 0;
            chk("en_in_reset", {30'd0, write_en, read_en}, 32'd0);
        end else begin
            chk("cmd_ready_vs_occ", cmd_ready, occ < DEPTH);
            chk("rsp_valid_vs_occ", rsp_valid, rocc > 0);
            chk("busy_vs_occ", busy, (occ > 0) || (rocc > 0));
            if (write_en || read_en) chk("one_issue_per_cycle", write_en & read_en, 1'b0);
            if (write_en) begin
                chk("write_rdy_at_en", write_rdy, 1'b1);
                chk("write_expected", exp_wr_q.size() > 0, 1'b1);
                if (exp_wr_q.size() > 0) begin
                    mon_w = exp_wr_q.pop_front();
                    chk("write_address", write_address, mon_w.addr);
                    chk("write_data", write_data, mon_w.data);
                end
            end
            if (read_en) begin
                chk("read_rdy_at_en", read_rdy, 1'b1);
                chk("read_expected", exp_rd_q.size() > 0, 1'b1);
                if (exp_rd_q.size() > 0) begin
                    mon_a = exp_rd_q.pop_front();
                    chk("read_address", read_address, mon_a);
                end
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", exp_rsp_q.size() > 0, 1'b1);
                if (exp_rsp_q.size() > 0) begin
                    mon_r = exp_rsp_q.pop_front();
                    chk("rsp_addr", rsp_addr, mon_r.addr);
                    chk("rsp_data", rsp_data, mon_r.data);
                end
            end
            occ  = occ + int'(cmd_valid && cmd_ready) - int'(write_en || read_en);
            rocc = rocc + int'(read_en) - int'(rsp_valid && rsp_ready);
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic neg();
        @(negedge CLK);
    endtask

    task automatic drive_cmd(input logic v, input logic op, input logic [2:0] a, input logic d);
        cmd_valid = v;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (busy && n < 100) begin
            cyc();
            n++;
        end
        chk(name, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_cnt;
        RST_N     = 1'b1;
        drive_cmd(1'b0, OP_WRITE, 3'd0, 1'b0);
        rsp_ready = 1'b1;
        write_rdy = 1'b1;
        read_rdy  = 1'b1;
        #2 RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;

        // Idle after reset
        neg();
        chk("t1_cmd_ready", cmd_ready, 1'b1);
        chk("t1_rsp_valid", rsp_valid, 1'b0);
        chk("t1_write_en", write_en, 1'b0);
        chk("t1_read_en", read_en, 1'b0);
        chk("t1_busy", busy, 1'b0);
        chk("t1_stall_cnt", stall_cnt, 16'd0);
        chk("t1_err", err_timeout, 1'b0);

        // Single write, issues the cycle after acceptance
        cyc();
        drive_cmd(1'b1, OP_WRITE, 3'd4, 1'b1);
        neg();
        chk("t2_no_bypass", write_en, 1'b0);
        cyc();
        cmd_valid = 1'b0;
        neg();
        chk("t2_write_en", write_en, 1'b1);
        chk("t2_write_address", write_address, 3'd4);
        chk("t2_write_data", write_data, 1'b1);
        cyc();
        neg();
        chk("t2_write_en_once", write_en, 1'b0);
        chk("t2_busy", busy, 1'b0);

        // Single read of address 3 (memory holds 1 there)
        cyc();
        drive_cmd(1'b1, OP_READ, 3'd3, 1'b0);
        neg();
        cyc();
        cmd_valid = 1'b0;
        neg();
        chk("t3_read_en", read_en, 1'b1);
        chk("t3_read_address", read_address, 3'd3);
        cyc();
        neg();
        chk("t3_read_en_once", read_en, 1'b0);
        chk("t3_rsp_valid", rsp_valid, 1'b1);
        chk("t3_rsp_addr", rsp_addr, 3'd3);
        chk("t3_rsp_data", rsp_data, 1'b1);
        cyc();
        neg();
        chk("t3_rsp_popped", rsp_valid, 1'b0);

        // Fill the command queue behind a blocked write method
        cyc();
        write_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_cmd(1'b1, OP_WRITE, (k == 3) ? 3'd5 : 3'(k), 1'(k));
            neg();
            chk("t4_ready_before_push", cmd_ready, 1'b1);
            chk("t4_stall_count", stall_cnt, (k < 2) ? 16'd0 : 16'(k - 1));
            cyc();
        end
        cmd_valid = 1'b0;
        neg();
        chk("t4_cmd_full", cmd_ready, 1'b0);
        chk("t4_stall_3", stall_cnt, 16'd3);
        cyc();
        neg();
        chk("t4_stall_4", stall_cnt, 16'd4);
        cyc();
        write_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            neg();
            chk("t4_burst_write_en", write_en, 1'b1);
            cyc();
        end
        neg();
        chk("t4_burst_done", write_en, 1'b0);
        chk("t4_stall_cleared", stall_cnt, 16'd0);
        chk("t4_no_err", err_timeout, 1'b0);
        chk("t4_busy", busy, 1'b0);

        // Response back-pressure: only four reads fit, the fifth waits for a pop
        cyc();
        rsp_ready = 1'b0;
        rd_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            drive_cmd(1'b1, OP_READ, 3'(7 - k), 1'b0);
            neg();
            if (read_en) rd_cnt++;
            cyc();
        end
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            neg();
            if (read_en) rd_cnt++;
            cyc();
        end
        chk("t5_read_pulses", rd_cnt, 4);
        rsp_ready = 1'b1;
        neg();
        chk("t5_held_while_full", read_en, 1'b0);
        cyc();
        rsp_ready = 1'b0;
        neg();
        chk("t5_fifth_issues", read_en, 1'b1);
        chk("t5_fifth_address", read_address, 3'd3);
        cyc();
        neg();
        chk("t5_fifth_once", read_en, 1'b0);
        cyc();
        rsp_ready = 1'b1;
        drain("t5_drained");

        // Timeout on a blocked write head; sticky after the write finally issues
        write_rdy = 1'b0;
        drive_cmd(1'b1, OP_WRITE, 3'd6, 1'b1);
        cyc();
        cmd_valid = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            cyc();
            chk("t6_stall_cnt", stall_cnt, 16'(k));
            chk("t6_err_timeout", err_timeout, k >= TMO);
        end
        write_rdy = 1'b1;
        neg();
        chk("t6_write_after_stall", write_en, 1'b1);
        cyc();
        chk("t6_err_sticky", err_timeout, 1'b1);
        chk("t6_stall_cleared", stall_cnt, 16'd0);

        // Reset with commands and a response queued
        rsp_ready = 1'b0;
        write_rdy = 1'b0;
        drive_cmd(1'b1, OP_READ, 3'd2, 1'b0);
        cyc();
        drive_cmd(1'b1, OP_WRITE, 3'd1, 1'b1);
        neg();
        chk("t6_queued_read_issues", read_en, 1'b1);
        cyc();
        drive_cmd(1'b1, OP_WRITE, 3'd5, 1'b0);
        cyc();
        cmd_valid = 1'b0;
        neg();
        chk("t6_pre_reset_busy", busy, 1'b1);
        chk("t6_pre_reset_rsp", rsp_valid, 1'b1);
        cyc();
        RST_N     = 1'b0;
        write_rdy = 1'b1;
        read_rdy  = 1'b1;
        neg();
        chk("t6_rst_write_en", write_en, 1'b0);
        chk("t6_rst_cmd_ready", cmd_ready, 1'b1);
        chk("t6_rst_rsp_valid", rsp_valid, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_err", err_timeout, 1'b0);
        chk("t6_rst_stall", stall_cnt, 16'd0);
        cyc();
        cyc();
        RST_N     = 1'b1;
        rsp_ready = 1'b1;
        cyc();

        // Random traffic against the scoreboard
        for (int i = 0; i < 600; i++) begin
            drive_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            write_rdy = ($urandom_range(0, 3) != 0);
            read_rdy  = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 4) < 3);
            cyc();
        end
        cmd_valid = 1'b0;
        write_rdy = 1'b1;
        read_rdy  = 1'b1;
        rsp_ready = 1'b1;
        drain("rand_drained");
        neg();
        chk("rand_wr_q_empty", exp_wr_q.size(), 0);
        chk("rand_rd_q_empty", exp_rd_q.size(), 0);
        chk("rand_rsp_q_empty", exp_rsp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
